// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART receive and transmit paths.
//   uart_state_t  : receiver/transmitter frame states
//   uart_rx_evt_t : per-frame completion strobes (good byte, framing, parity)
//   CLKS_PER_BIT_115200 : divider for 115200 baud from the 100 MHz board clock
//   DATA_BITS_DEFAULT   : payload width of a standard frame
package uart_pkg;

   localparam int CLKS_PER_BIT_115200 = 868;
   localparam int DATA_BITS_DEFAULT   = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_IDLE
   } uart_state_t;

   typedef struct packed {
      logic valid;
      logic frame_err;
      logic parity_err;
   } uart_rx_evt_t;

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2 -- two-flop synchronizer for an asynchronous pin input.
// Resets to 1 so an idle-high serial line does not look like a start bit
// while the flops are filling after reset.
//   i_clock   : destination clock
//   i_reset_n : synchronous reset, active low
//   i_d       : asynchronous input
//   o_q       : synchronized output, two cycles behind i_d
module uart_sync2 (
   input  logic i_clock,
   input  logic i_reset_n,
   input  logic i_d,
   output logic o_q
);

   logic meta;

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         meta <= 1'b1;
         o_q  <= 1'b1;
      end else begin
         meta <= i_d;
         o_q  <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- fixed-divider serial receiver, LSB first, idle-high line.
// Frame is 8N1 by default; defining UART_RX_PARITY_EN adds an even-parity bit
// (8E1) between the data and the stop bit. The port list is the same either way.
//   i_clock      : system clock, rising edge
//   i_reset_n    : synchronous reset, active low
//   i_signal     : asynchronous serial line (idle high)
//   o_data       : last good byte, held until the next good frame
//   o_valid      : one-cycle pulse, o_data updated this cycle
//   o_busy       : high while a frame (or a break after it) is in progress
//   o_frame_err  : one-cycle pulse, stop bit sampled low
//   o_parity_err : one-cycle pulse, parity mismatch (constant 0 in 8N1 builds)
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
   parameter int DATA_BITS    = DATA_BITS_DEFAULT
) (
   input  logic                 i_clock,
   input  logic                 i_reset_n,
   input  logic                 i_signal,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   output logic                 o_busy,
   output logic                 o_frame_err,
   output logic                 o_parity_err
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] BAUD_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   uart_state_t          state, state_n;
   logic                 rx_s;
   logic [CW-1:0]        baud_cnt;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shift;
   logic                 baud_tick;
   logic                 shift_en;
   uart_rx_evt_t         evt_n, evt_q;
`ifdef UART_RX_PARITY_EN
   logic                 par_sample;
   logic                 par_bad;
`endif

   uart_sync2 u_sync (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_d       (i_signal),
      .o_q       (rx_s)
   );

   assign baud_tick = (baud_cnt == BAUD_LAST);

   // State register
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) state <= IDLE;
      else            state <= state_n;
   end

   // Next state and per-cycle strobes
   always_comb begin
      state_n  = state;
      shift_en = 1'b0;
      evt_n    = '0;
`ifdef UART_RX_PARITY_EN
      par_sample = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (!rx_s) state_n = START;
         end
         START: begin
            // mid start bit: still low means a real frame, high was a glitch
            if (baud_cnt == BAUD_HALF) state_n = rx_s ? IDLE : DATA;
         end
         DATA: begin
            if (baud_tick) begin
               shift_en = 1'b1;
               if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (baud_tick) begin
               par_sample = 1'b1;
               state_n    = STOP;
            end
         end
`endif
         STOP: begin
            // leaving mid stop bit leaves half a bit to catch the next start edge
            if (baud_tick) begin
               if (!rx_s) begin
                  evt_n.frame_err = 1'b1;
                  state_n         = WAIT_IDLE;
               end else begin
                  state_n = IDLE;
`ifdef UART_RX_PARITY_EN
                  if (par_bad) evt_n.parity_err = 1'b1;
                  else         evt_n.valid      = 1'b1;
`else
                  evt_n.valid = 1'b1;
`endif
               end
            end
         end
         WAIT_IDLE: begin
            // hold off through a break until the line is released
            if (rx_s) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Datapath: baud/bit counters, shift register, output registers
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         o_data   <= '0;
         evt_q    <= '0;
      end else begin
         if (state_n != state) baud_cnt <= '0;
         else if (baud_tick)   baud_cnt <= '0;
         else                  baud_cnt <= baud_cnt + 1'b1;

         if (shift_en) begin
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
         end

         if (evt_n.valid) o_data <= shift;
         evt_q <= evt_n;
      end
   end

`ifdef UART_RX_PARITY_EN
   // even parity: line bit must equal the XOR of the data bits
   always_ff @(posedge i_clock) begin
      if (!i_reset_n)      par_bad <= 1'b0;
      else if (par_sample) par_bad <= rx_s ^ (^shift);
   end
`endif

   assign o_valid      = evt_q.valid;
   assign o_frame_err  = evt_q.frame_err;
   assign o_parity_err = evt_q.parity_err;
   assign o_busy       = (state != IDLE);

endmodule
